// File: rtl/gray_ptr_sync_checked.sv
// Read-domain synchroniser for a Gray-coded write pointer, with registered
// binary copy, advance pulse/delta and a sticky illegal-transition flag.
module gray_ptr_sync_checked #(
  parameter int ADDRESS  = 3,
  parameter int STAGES   = 2,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic               read_clk,
  input  logic               read_rst_n,
  input  logic [ADDRESS:0]   write_ptr_gray,
  input  logic               error_clr,
  output logic [ADDRESS:0]   sync_write_ptr,
  output logic [ADDRESS:0]   sync_write_ptr_bin,
  output logic               ptr_advanced,
  output logic [ADDRESS:0]   ptr_delta,
  output logic               gray_error
);

  localparam int W = ADDRESS + 1;
  localparam logic [ADDRESS:0] ONE = {{ADDRESS{1'b0}}, 1'b1};

  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("gray_ptr_sync_checked: STAGES must be in 2..4");
    end
  endgenerate

  (* async_reg = "true" *) logic [ADDRESS:0] chain [STAGES];

  logic [ADDRESS:0] prev_sync;
  logic [ADDRESS:0] bin_next;
  logic [ADDRESS:0] sync_diff;
  logic             multi_bit;
  logic             violation;

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= write_ptr_gray;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign sync_write_ptr = chain[STAGES-1];

  // Binary bit i is the parity of all Gray bits at or above i.
  always_comb begin
    bin_next = '0;
    for (int i = 0; i < W; i++) bin_next[i] = ^(sync_write_ptr >> i);
  end

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign sync_diff = sync_write_ptr ^ prev_sync;
  assign multi_bit = |(sync_diff & (sync_diff - ONE));
  assign violation = CHECK_EN && multi_bit;

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      prev_sync          <= '0;
      sync_write_ptr_bin <= '0;
      ptr_advanced       <= 1'b0;
      ptr_delta          <= '0;
      gray_error         <= 1'b0;
    end else begin
      prev_sync          <= sync_write_ptr;
      sync_write_ptr_bin <= bin_next;
      if (bin_next != sync_write_ptr_bin) begin
        ptr_advanced <= 1'b1;
        ptr_delta    <= bin_next - sync_write_ptr_bin;
      end else begin
        ptr_advanced <= 1'b0;
      end
      // A fresh violation outranks a simultaneous clear.
      if (violation)      gray_error <= 1'b1;
      else if (error_clr) gray_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync_checked.sv
// Randomised and directed bench for gray_ptr_sync_checked (STAGES=2 and 4),
// checked against a sample-history reference model.
module tb_gray_ptr_sync_checked;

  localparam int A = 3;

  logic         read_clk;
  logic         read_rst_n;
  logic [A:0]   write_ptr_gray;
  logic         error_clr;

  logic [A:0]   sync2, bin2, delta2, sync4, bin4, delta4;
  logic         adv2, err2, adv4, err4;

  gray_ptr_sync_checked #(.ADDRESS(A), .STAGES(2), .CHECK_EN(1'b1)) u_s2 (
    .read_clk(read_clk), .read_rst_n(read_rst_n),
    .write_ptr_gray(write_ptr_gray), .error_clr(error_clr),
    .sync_write_ptr(sync2), .sync_write_ptr_bin(bin2),
    .ptr_advanced(adv2), .ptr_delta(delta2), .gray_error(err2));

  gray_ptr_sync_checked #(.ADDRESS(A), .STAGES(4), .CHECK_EN(1'b1)) u_s4 (
    .read_clk(read_clk), .read_rst_n(read_rst_n),
    .write_ptr_gray(write_ptr_gray), .error_clr(error_clr),
    .sync_write_ptr(sync4), .sync_write_ptr_bin(bin4),
    .ptr_advanced(adv4), .ptr_delta(delta4), .gray_error(err4));

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: in_hist[k] is the input sampled at the k-th edge since reset.
  logic [A:0] in_hist[$];
  int         n;
  logic       err_m   [2];
  logic [A:0] delta_m [2];

  function automatic logic [A:0] g2b(input logic [A:0] g);
    logic [A:0] b, sh;
    b  = g;
    sh = g >> 1;
    while (sh != 0) begin
      b  = b ^ sh;
      sh = sh >> 1;
    end
    return b;
  endfunction

  // Synchronised value after k edges for a chain of st flops.
  function automatic logic [A:0] s_at(input int k, input int st);
    if (k < st) return '0;
    return in_hist[k-st+1];
  endfunction

  function automatic int stg(input int j);
    return (j == 0) ? 2 : 4;
  endfunction

  task automatic model_reset();
    in_hist.delete();
    in_hist.push_back('0);
    n = 0;
    for (int j = 0; j < 2; j++) begin
      err_m[j]   = 1'b0;
      delta_m[j] = '0;
    end
  endtask

  task automatic check_outputs();
    logic [A:0] nb, ob;
    nb = g2b(s_at(n-1, 2)); ob = g2b(s_at(n-2, 2));
    check("s2_sync",  32'(sync2),  32'(s_at(n, 2)));
    check("s2_bin",   32'(bin2),   32'(nb));
    check("s2_adv",   32'(adv2),   32'(n >= 1 && nb != ob));
    check("s2_delta", 32'(delta2), 32'(delta_m[0]));
    check("s2_err",   32'(err2),   32'(err_m[0]));
    nb = g2b(s_at(n-1, 4)); ob = g2b(s_at(n-2, 4));
    check("s4_sync",  32'(sync4),  32'(s_at(n, 4)));
    check("s4_bin",   32'(bin4),   32'(nb));
    check("s4_adv",   32'(adv4),   32'(n >= 1 && nb != ob));
    check("s4_delta", 32'(delta4), 32'(delta_m[1]));
    check("s4_err",   32'(err4),   32'(err_m[1]));
  endtask

  task automatic tick();
    logic [A:0] nb, ob;
    @(posedge read_clk);
    if (read_rst_n) begin
      n++;
      in_hist.push_back(write_ptr_gray);
      for (int j = 0; j < 2; j++) begin
        nb = g2b(s_at(n-1, stg(j)));
        ob = g2b(s_at(n-2, stg(j)));
        if (nb != ob) delta_m[j] = nb - ob;
        if ($countones(s_at(n-1, stg(j)) ^ s_at(n-2, stg(j))) > 1) err_m[j] = 1'b1;
        else if (error_clr) err_m[j] = 1'b0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic [A:0] g, input int cycles);
    write_ptr_gray = g;
    repeat (cycles) tick();
  endtask

  task automatic clr_pulse();
    error_clr = 1'b1;
    tick();
    error_clr = 1'b0;
  endtask

  logic [A:0] wptr;

  initial begin
    read_rst_n     = 1'b0;
    write_ptr_gray = 4'b0110;
    error_clr      = 1'b0;
    model_reset();
    #2;
    check_outputs();
    tick();
    tick();
    @(negedge read_clk);
    read_rst_n = 1'b1;

    // Reset release with 0110 held
    tick(); tick();
    check("rel_sync", 32'(sync2), 32'h6);
    tick();
    check("rel_bin",   32'(bin2),   32'h4);
    check("rel_adv",   32'(adv2),   32'h1);
    check("rel_delta", 32'(delta2), 32'h4);
    hold(4'b0110, 4);

    // Single-step Gray sequence
    hold(4'b0010, 6);
    clr_pulse();
    hold(4'b0000, 6);
    hold(4'b0001, 6);
    hold(4'b0011, 6);
    hold(4'b0010, 6);
    check("step_err", 32'(err2), 32'h0);

    // Wrap 15 -> 0
    hold(4'b1000, 6);
    clr_pulse();
    hold(4'b0000, 2);
    tick();
    check("wrap_delta", 32'(delta2), 32'h1);
    check("wrap_adv",   32'(adv2),   32'h1);
    hold(4'b0000, 4);
    check("wrap_bin", 32'(bin2), 32'h0);
    check("wrap_err", 32'(err2), 32'h0);

    // Multi-step jump 0001 -> 0010 between samples
    hold(4'b0001, 6);
    hold(4'b0010, 6);
    check("multi_delta", 32'(delta2), 32'h2);
    check("multi_err",   32'(err2),   32'h1);

    // Asynchronous reset while gray_error is set
    #2;
    read_rst_n = 1'b0;
    #1;
    check("arst_sync",  32'(sync2),  32'h0);
    check("arst_bin",   32'(bin2),   32'h0);
    check("arst_adv",   32'(adv2),   32'h0);
    check("arst_delta", 32'(delta2), 32'h0);
    check("arst_err",   32'(err2),   32'h0);
    check("arst_err4",  32'(err4),   32'h0);
    model_reset();
    write_ptr_gray = 4'b0000;
    tick(); tick();
    @(negedge read_clk);
    read_rst_n = 1'b1;

    // Error clear after a multi-bit jump
    hold(4'b0001, 6);
    hold(4'b0010, 6);
    clr_pulse();
    check("clr_err", 32'(err2), 32'h0);
    hold(4'b0010, 3);

    // Random write-side advance, sampled once per read cycle
    wptr = 4'd3;
    for (int c = 0; c < 400; c++) begin
      wptr = wptr + 4'($urandom_range(0, 3) == 0 ? $urandom_range(2, 5) : $urandom_range(0, 1));
      write_ptr_gray = wptr ^ (wptr >> 1);
      error_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    error_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
